// File: rtl/bin_to_bcd_seg.sv
// Serial double-dabble binary-to-BCD converter with registered active-low 7-segment outputs.
// Latency: done pulses WIDTH+1 cycles after the accepting start edge; a new start is accepted WIDTH+2 cycles after the previous one at the earliest.
// Backpressure: none; start is sampled only while idle, and requests arriving while busy are dropped.
module bin_to_bcd_seg #(
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 3,
    parameter int BLANK_LZ = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]          state;
    logic [CW-1:0]       cnt;
    logic [WIDTH-1:0]    sr;
    logic [4*DIGITS-1:0] scratch;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS-1:0] nxt_scratch;
    logic [WIDTH-1:0]    nxt_sr;
    logic [7*DIGITS-1:0] seg_nxt;
    logic                lead;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = 7'b1111111;
        endcase
    endfunction

    // One double-dabble step: correct every digit, then shift the next input bit in.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
            end
        end
        nxt_scratch = (adj << 1) | {{(4*DIGITS-1){1'b0}}, sr[WIDTH-1]};
        nxt_sr      = sr << 1;
    end

    // Blanking walks from the top digit down; the units digit is always shown.
    always_comb begin
        seg_nxt = '1;
        lead    = 1'b1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (nxt_scratch[4*i +: 4] != 4'd0) begin
                lead = 1'b0;
            end
            if ((BLANK_LZ != 0) && lead && (i != 0)) begin
                seg_nxt[7*i +: 7] = 7'b1111111;
            end else begin
                seg_nxt[7*i +: 7] = seg_code(nxt_scratch[4*i +: 4]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            cnt     <= '0;
            sr      <= '0;
            scratch <= '0;
            bcd     <= '0;
            seg     <= '1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        sr      <= in;
                        scratch <= '0;
                        cnt     <= '0;
                        state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    sr      <= nxt_sr;
                    scratch <= nxt_scratch;
                    if (cnt == LAST) begin
                        cnt   <= '0;
                        state <= S_DONE;
                        bcd   <= nxt_scratch;
                        seg   <= seg_nxt;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule
